// File: rtl/uplink_frame_capture_pkg.sv
// Shared constants, state encoding and helpers for the uplink frame capture block.
package uplink_frame_capture_pkg;

    localparam int FRAME_W_DEF     = 234;
    localparam int WORDS_PER_FRAME = 8;
    localparam int TS_WORD_IDX     = 8;
    localparam int FEC_CNT_W       = 16;
    localparam int RD_WORD_W       = 4;
    localparam int TS_W            = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_e;

    function automatic logic [FEC_CNT_W-1:0] fec_sat_inc(input logic [FEC_CNT_W-1:0] v);
        return (&v) ? v : v + FEC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uplink_frame_capture_ram.sv
// Capture buffer: DEPTH entries, one synchronous write port, one registered read port.
module uplink_cap_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 234
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // NOTE: the array itself is never reset so it maps onto block RAM; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reading the array before the write edge gives old data on a same-index collision.
    always_comb begin
        rd_data_d = rd_en_i ? mem_q[rd_addr_i] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uplink_frame_capture.sv
// Snapshot of DEPTH consecutive lpGBT uplink frames with 32-bit readback and FEC counter.
// Define UPLINK_FRAME_CAPTURE_TIMESTAMP_EN to store an accepted-frame timestamp per entry (read word 8).
module uplink_frame_capture
    import uplink_frame_capture_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 frame_valid_i,
    input  logic [FRAME_W-1:0]   frame_data_i,
    input  logic                 frame_fec_i,
    input  logic                 uplink_rdy_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 trig_mode_i,
    input  logic [31:0]          trig_mask_i,
    input  logic [31:0]          trig_value_i,
    input  logic                 rd_req_i,
    input  logic [ADDR_W-1:0]    rd_frame_i,
    input  logic [RD_WORD_W-1:0] rd_word_i,
    output logic [31:0]          rd_data_o,
    output logic                 rd_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ADDR_W:0]      cap_count_o,
    output logic [FEC_CNT_W-1:0] fec_cnt_o,
    output logic                 rdy_lost_o
);

`ifdef UPLINK_FRAME_CAPTURE_TIMESTAMP_EN
    localparam int MEM_W = FRAME_W + TS_W;
`else
    localparam int MEM_W = FRAME_W;
`endif
    localparam int PAD_W = WORDS_PER_FRAME * 32;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]      cap_count_q, cap_count_d;
    logic [FEC_CNT_W-1:0] fec_cnt_q, fec_cnt_d;
    logic                 rdy_lost_q, rdy_lost_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [RD_WORD_W-1:0] rd_word_q, rd_word_d;

    logic                 accepted;
    logic                 match;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [MEM_W-1:0]     wr_data;
    logic [MEM_W-1:0]     rd_mem;
    logic [PAD_W-1:0]     rd_padded;

    assign accepted = frame_valid_i & uplink_rdy_i;
    assign match    = ((frame_data_i[31:0] ^ trig_value_i) & trig_mask_i) == 32'h0;

`ifdef UPLINK_FRAME_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = accepted ? ts_q + TS_W'(1) : ts_q;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_data = {ts_q, frame_data_i};
`else
    assign wr_data = frame_data_i;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cap_count_d = cap_count_q;
        rdy_lost_d  = rdy_lost_q;
        fec_cnt_d   = (accepted && frame_fec_i) ? fec_sat_inc(fec_cnt_q) : fec_cnt_q;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_q;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm_i) begin
                        state_d     = ARMED;
                        wr_ptr_d    = '0;
                        cap_count_d = '0;
                        fec_cnt_d   = '0;
                        rdy_lost_d  = 1'b0;
                    end
                end
                ARMED: begin
                    if (!uplink_rdy_i) begin
                        rdy_lost_d = 1'b1;
                        state_d    = DONE;
                    end else if (accepted && (!trig_mode_i || match)) begin
                        wr_en       = 1'b1;
                        wr_addr     = '0;
                        wr_ptr_d    = ADDR_W'(1);
                        cap_count_d = (ADDR_W+1)'(1);
                        state_d     = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!uplink_rdy_i) begin
                        rdy_lost_d = 1'b1;
                        state_d    = DONE;
                    end else if (accepted) begin
                        wr_en       = 1'b1;
                        wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                        cap_count_d = cap_count_q + (ADDR_W+1)'(1);
                        if (cap_count_q == (ADDR_W+1)'(DEPTH - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rd_valid_d = rd_req_i;
        rd_word_d  = rd_req_i ? rd_word_i : rd_word_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cap_count_q <= '0;
            fec_cnt_q   <= '0;
            rdy_lost_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cap_count_q <= cap_count_d;
            fec_cnt_q   <= fec_cnt_d;
            rdy_lost_q  <= rdy_lost_d;
            rd_valid_q  <= rd_valid_d;
            rd_word_q   <= rd_word_d;
        end
    end

    uplink_cap_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (MEM_W)
    ) u_ram (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_req_i),
        .rd_addr_i (rd_frame_i),
        .rd_data_o (rd_mem)
    );

    // Zero-padding the frame to whole words makes the top word's unused bits read as 0.
    always_comb begin
        rd_padded              = '0;
        rd_padded[FRAME_W-1:0] = rd_mem[FRAME_W-1:0];
        rd_data_o              = 32'h0;
        if (rd_word_q < RD_WORD_W'(WORDS_PER_FRAME)) begin
            rd_data_o = rd_padded[{rd_word_q[2:0], 5'd0} +: 32];
        end
`ifdef UPLINK_FRAME_CAPTURE_TIMESTAMP_EN
        if (rd_word_q == RD_WORD_W'(TS_WORD_IDX)) begin
            rd_data_o = rd_mem[MEM_W-1 -: TS_W];
        end
`endif
    end

    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = (state_q == ARMED) || (state_q == CAPTURE);
    assign done_o      = (state_q == DONE);
    assign cap_count_o = cap_count_q;
    assign fec_cnt_o   = fec_cnt_q;
    assign rdy_lost_o  = rdy_lost_q;

endmodule

// File: tb/tb_uplink_frame_capture.sv
// Scenario bench for uplink_frame_capture: read expectations are queued at request time and popped on rd_valid_o.
module tb_uplink_frame_capture;

    localparam int FRAME_W = 234;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;

    logic                S_AXI_ACLK = 1'b0;
    logic                S_AXI_ARESETN;
    logic                frame_valid_i;
    logic [FRAME_W-1:0]  frame_data_i;
    logic                frame_fec_i;
    logic                uplink_rdy_i;
    logic                arm_i;
    logic                abort_i;
    logic                trig_mode_i;
    logic [31:0]         trig_mask_i;
    logic [31:0]         trig_value_i;
    logic                rd_req_i;
    logic [ADDR_W-1:0]   rd_frame_i;
    logic [3:0]          rd_word_i;
    logic [31:0]         rd_data_o;
    logic                rd_valid_o;
    logic                busy_o;
    logic                done_o;
    logic [ADDR_W:0]     cap_count_o;
    logic [15:0]         fec_cnt_o;
    logic                rdy_lost_o;

    int unsigned total;
    int unsigned bad;
    int unsigned acc_cnt;
    logic [31:0] exp_q [$];

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    uplink_frame_capture #(
        .FRAME_W (FRAME_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .frame_valid_i (frame_valid_i),
        .frame_data_i  (frame_data_i),
        .frame_fec_i   (frame_fec_i),
        .uplink_rdy_i  (uplink_rdy_i),
        .arm_i         (arm_i),
        .abort_i       (abort_i),
        .trig_mode_i   (trig_mode_i),
        .trig_mask_i   (trig_mask_i),
        .trig_value_i  (trig_value_i),
        .rd_req_i      (rd_req_i),
        .rd_frame_i    (rd_frame_i),
        .rd_word_i     (rd_word_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cap_count_o   (cap_count_o),
        .fec_cnt_o     (fec_cnt_o),
        .rdy_lost_o    (rdy_lost_o)
    );

    function automatic logic [FRAME_W-1:0] gen_frame(input int k);
        logic [FRAME_W-1:0] f;
        f        = '0;
        f[31:0]  = 32'(k);
        for (int w = 1; w < 7; w++) begin
            f[32*w +: 32] = 32'(k) * 32'h9E37_79B1 + 32'(w);
        end
        f[233:224] = 10'(k * 3 + 1);
        return f;
    endfunction

    function automatic logic [31:0] word_of(input logic [FRAME_W-1:0] f, input int w);
        if (w < 7)  return f[32*w +: 32];
        if (w == 7) return {22'b0, f[233:224]};
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic drive_frame(input logic [FRAME_W-1:0] d, input logic fec);
        frame_valid_i = 1'b1;
        frame_data_i  = d;
        frame_fec_i   = fec;
        if (uplink_rdy_i) acc_cnt++;
        tick();
        frame_valid_i = 1'b0;
        frame_fec_i   = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    task automatic expect_read(input string name);
        logic [31:0] e;
        total++;
        if (rd_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: rd_valid_o=%b required 1", name, rd_valid_o);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            total++;
            if (rd_data_o !== e) begin
                bad++;
                $display("FAIL %s: rd_data_o=%08h required %08h", name, rd_data_o, e);
            end
        end
    endtask

    task automatic do_read(input int fr, input int wd, input logic [31:0] e, input string name);
        exp_q.push_back(e);
        rd_req_i   = 1'b1;
        rd_frame_i = ADDR_W'(fr);
        rd_word_i  = 4'(wd);
        tick();
        rd_req_i   = 1'b0;
        expect_read(name);
    endtask

    task automatic test_reset();
        S_AXI_ARESETN = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy_o, done_o, rdy_lost_o, rd_valid_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: busy,done,rdy_lost,rd_valid=%b required 0000",
                     {busy_o, done_o, rdy_lost_o, rd_valid_o});
        end
        total++;
        if (cap_count_o !== '0 || fec_cnt_o !== 16'h0 || rd_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: cap=%0d fec=%0h rd_data=%08h required 0 0 0",
                     cap_count_o, fec_cnt_o, rd_data_o);
        end
        S_AXI_ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_free_capture();
        trig_mode_i = 1'b0;
        pulse_arm();
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL free_armed: busy=%b done=%b required 1 0", busy_o, done_o);
        end
        for (int k = 0; k < 20; k++) begin
            drive_frame(gen_frame(k), 1'b0);
            if (k == 14) begin
                total++;
                if (cap_count_o !== 5'd15 || done_o !== 1'b0) begin
                    bad++;
                    $display("FAIL free_penultimate: cap=%0d done=%b required 15 0", cap_count_o, done_o);
                end
            end
        end
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || cap_count_o !== 5'd16) begin
            bad++;
            $display("FAIL free_done: done=%b busy=%b cap=%0d required 1 0 16", done_o, busy_o, cap_count_o);
        end
        do_read(0, 0, 32'd0, "free_f0w0");
        do_read(15, 0, 32'd15, "free_f15w0");
        tick();
        total++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== 32'd15) begin
            bad++;
            $display("FAIL free_hold: rd_valid=%b rd_data=%08h required 0 0000000f", rd_valid_o, rd_data_o);
        end
        do_read(15, 7, word_of(gen_frame(15), 7), "free_f15w7");
        do_read(7, 3, word_of(gen_frame(7), 3), "free_f7w3");
        do_read(15, 12, 32'h0, "free_f15w12");
    endtask

    task automatic test_pattern();
        trig_mode_i  = 1'b1;
        trig_mask_i  = 32'hFFFF_FFFF;
        trig_value_i = 32'h0000_0007;
        pulse_arm();
        for (int k = 0; k <= 30; k++) begin
            drive_frame(gen_frame(k), 1'b0);
            if (k == 6) begin
                total++;
                if (busy_o !== 1'b1 || cap_count_o !== 5'd0) begin
                    bad++;
                    $display("FAIL pat_waiting: busy=%b cap=%0d required 1 0", busy_o, cap_count_o);
                end
            end
        end
        total++;
        if (done_o !== 1'b1 || cap_count_o !== 5'd16) begin
            bad++;
            $display("FAIL pat_done: done=%b cap=%0d required 1 16", done_o, cap_count_o);
        end
        do_read(0, 0, 32'd7, "pat_f0w0");
        do_read(15, 0, 32'd22, "pat_f15w0");
        do_read(4, 5, word_of(gen_frame(11), 5), "pat_f4w5");

        // Only bits [7:4] are compared; the value's other bits must be ignored.
        trig_mask_i  = 32'h0000_00F0;
        trig_value_i = 32'hABCD_EF5A;
        pulse_arm();
        for (int k = 'h40; k <= 'h62; k++) drive_frame(gen_frame(k), 1'b0);
        do_read(0, 0, 32'h50, "mask_f0w0");
        do_read(15, 0, 32'h5F, "mask_f15w0");
        trig_mode_i = 1'b0;
    endtask

    task automatic test_rdy_lost();
        pulse_arm();
        for (int k = 0; k < 5; k++) drive_frame(gen_frame(200 + k), 1'b0);
        uplink_rdy_i = 1'b0;
        tick();
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || cap_count_o !== 5'd5 || rdy_lost_o !== 1'b1) begin
            bad++;
            $display("FAIL rdy_lost: done=%b busy=%b cap=%0d lost=%b required 1 0 5 1",
                     done_o, busy_o, cap_count_o, rdy_lost_o);
        end
        drive_frame(gen_frame(999), 1'b1);
        do_read(4, 0, 32'd204, "rdy_f4w0");
        uplink_rdy_i = 1'b1;
        pulse_arm();
        total++;
        if (rdy_lost_o !== 1'b0 || cap_count_o !== 5'd0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rdy_rearm: lost=%b cap=%0d busy=%b required 0 0 1", rdy_lost_o, cap_count_o, busy_o);
        end
        pulse_abort();
    endtask

    task automatic test_fec_sat();
        pulse_arm();
        drive_frame('0, 1'b1);
        drive_frame('0, 1'b0);
        drive_frame('0, 1'b1);
        drive_frame('0, 1'b0);
        drive_frame('0, 1'b1);
        uplink_rdy_i = 1'b0;
        drive_frame('0, 1'b1);
        uplink_rdy_i = 1'b1;
        total++;
        if (fec_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL fec_count: fec_cnt=%0d required 3", fec_cnt_o);
        end
        for (int i = 0; i < 70000; i++) drive_frame('0, 1'b1);
        total++;
        if (fec_cnt_o !== 16'hFFFF) begin
            bad++;
            $display("FAIL fec_sat: fec_cnt=%04h required ffff", fec_cnt_o);
        end
        pulse_arm();
        total++;
        if (fec_cnt_o !== 16'h0) begin
            bad++;
            $display("FAIL fec_clear: fec_cnt=%04h required 0000", fec_cnt_o);
        end
        pulse_abort();
    endtask

    task automatic test_abort();
        pulse_arm();
        for (int k = 0; k < 3; k++) drive_frame(gen_frame(100 + k), 1'b0);
        pulse_arm();
        total++;
        if (busy_o !== 1'b1 || cap_count_o !== 5'd3) begin
            bad++;
            $display("FAIL arm_ignored: busy=%b cap=%0d required 1 3", busy_o, cap_count_o);
        end
        abort_i = 1'b1;
        arm_i   = 1'b1;
        tick();
        abort_i = 1'b0;
        arm_i   = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || cap_count_o !== 5'd3) begin
            bad++;
            $display("FAIL abort_wins: busy=%b done=%b cap=%0d required 0 0 3", busy_o, done_o, cap_count_o);
        end
        drive_frame(gen_frame(555), 1'b0);
        total++;
        if (busy_o !== 1'b0 || cap_count_o !== 5'd3) begin
            bad++;
            $display("FAIL idle_stays: busy=%b cap=%0d required 0 3", busy_o, cap_count_o);
        end
    endtask

    task automatic test_word_map();
        logic [FRAME_W-1:0] f;
        int unsigned        ts_exp;
        f          = gen_frame(300);
        f[233:224] = 10'h3FF;
        ts_exp     = acc_cnt;
        pulse_arm();
        drive_frame(f, 1'b0);

        // Write index 1 and read index 1 on the same edge: old contents come back.
        exp_q.push_back(32'd101);
        frame_valid_i = 1'b1;
        frame_data_i  = gen_frame(301);
        acc_cnt++;
        rd_req_i      = 1'b1;
        rd_frame_i    = ADDR_W'(1);
        rd_word_i     = 4'd0;
        tick();
        frame_valid_i = 1'b0;
        rd_req_i      = 1'b0;
        expect_read("collide_old");
        do_read(1, 0, 32'd301, "collide_new");

        do_read(0, 7, 32'h0000_03FF, "map_w7");
        do_read(0, 9, 32'h0, "map_w9");
        do_read(0, 15, 32'h0, "map_w15");
        do_read(0, 0, 32'd300, "map_w0");
`ifdef UPLINK_FRAME_CAPTURE_TIMESTAMP_EN
        do_read(0, 8, 32'(ts_exp), "map_ts");
`else
        do_read(0, 8, 32'h0, "map_w8");
`endif
        pulse_abort();
    endtask

    task automatic test_back_to_back_reads();
        exp_q.push_back(32'd300);
        exp_q.push_back(32'd301);
        rd_req_i   = 1'b1;
        rd_frame_i = ADDR_W'(0);
        rd_word_i  = 4'd0;
        tick();
        rd_frame_i = ADDR_W'(1);
        expect_read("b2b_first");
        tick();
        rd_req_i = 1'b0;
        expect_read("b2b_second");
        tick();
        total++;
        if (rd_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulse: rd_valid=%b required 0", rd_valid_o);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        acc_cnt       = 0;
        S_AXI_ARESETN = 1'b0;
        frame_valid_i = 1'b0;
        frame_data_i  = '0;
        frame_fec_i   = 1'b0;
        uplink_rdy_i  = 1'b1;
        arm_i         = 1'b0;
        abort_i       = 1'b0;
        trig_mode_i   = 1'b0;
        trig_mask_i   = 32'h0;
        trig_value_i  = 32'h0;
        rd_req_i      = 1'b0;
        rd_frame_i    = '0;
        rd_word_i     = '0;

        test_reset();
        test_free_capture();
        test_pattern();
        test_rdy_lost();
        test_fec_sat();
        test_abort();
        test_word_map();
        test_back_to_back_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uplink_frame_capture.md
Name: uplink_frame_capture

Overview:
- Downstream consumer of the lpGBT-FPGA uplink user-data stream: 234-bit frame, ready flag, FEC-corrected flag.
- Snapshots DEPTH consecutive uplink frames into an internal buffer, either immediately or on a masked pattern match.
- Buffer is read back as 32-bit words by the register/AXI slave logic.
- Also keeps a saturating count of FEC-corrected frames for link-quality monitoring.

Parameters:
- FRAME_W, 234, uplink user-data frame width.
- DEPTH, 16, frames per capture; must be a power of 2, ≥2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- S_AXI_ACLK  in  1  single clock for the block; all inputs are synchronous to it (upstream CDC delivers the uplink stream on it).
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- frame_valid_i  in  1  one-cycle strobe per uplink frame.
- frame_data_i  in  FRAME_W  uplink user data, qualified by frame_valid_i.
- frame_fec_i  in  1  frame had FEC corrections, qualified by frame_valid_i.
- uplink_rdy_i  in  1  uplink locked/ready level.
- arm_i  in  1  pulse: start a new capture.
- abort_i  in  1  pulse: cancel capture.
- trig_mode_i  in  1  0 = capture on first valid frame; 1 = capture on pattern match.
- trig_mask_i  in  32  compare mask on frame_data_i[31:0].
- trig_value_i  in  32  compare value.
- rd_req_i  in  1  read strobe.
- rd_frame_i  in  ADDR_W  frame index to read.
- rd_word_i  in  4  32-bit word index within the frame.
- rd_data_o  out  32  read data.
- rd_valid_o  out  1  read data valid.
- busy_o  out  1  state is ARMED or CAPTURE.
- done_o  out  1  state is DONE.
- cap_count_o  out  ADDR_W+1  frames stored in the current/last capture.
- fec_cnt_o  out  16  saturating count of FEC-flagged frames.
- rdy_lost_o  out  1  sticky: uplink_rdy_i fell during ARMED/CAPTURE.

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge):
  - State IDLE.
  - All outputs 0; write pointer 0.
  - Buffer contents not cleared.
- Accepted frame: frame_valid_i & uplink_rdy_i.
- Match: ((frame_data_i[31:0] ^ trig_value_i) & trig_mask_i) == 0.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE/DONE + arm_i → ARMED. On entry: clear wr_ptr, cap_count_o, fec_cnt_o, rdy_lost_o, done_o.
  - ARMED + accepted frame + (trig_mode_i=0 or match) → write frame at index 0, cap_count_o=1, then:
    - DEPTH>1 → CAPTURE.
  - CAPTURE + accepted frame → write at wr_ptr, increment cap_count_o. The write that makes cap_count_o==DEPTH → DONE in the same edge.
  - ARMED/CAPTURE + uplink_rdy_i==0 → rdy_lost_o=1, state DONE; cap_count_o holds the partial count.
  - abort_i in any state → IDLE; cap_count_o retained. abort_i wins over arm_i in the same cycle.
  - arm_i while ARMED/CAPTURE: ignored.
- Frames are written as presented; there is no gap detection.
- FEC counter:
  - Increments on each accepted frame with frame_fec_i=1, in every state.
  - Saturates at 0xFFFF; cleared only by reset or arm.
- Readout:
  - Timing: rd_req_i at cycle N → rd_data_o/rd_valid_o at cycle N+1. rd_valid_o is a one-cycle pulse.
  - Data: word w (0..6) = frame[32w+31:32w]; word 7 = {22'b0, frame[233:224]}; words 8..15 = 0.
  - rd_data_o holds its value between reads.
  - Reads are allowed in any state and never stall capture.
  - Same-cycle read and write of one index returns the old data.
  - Reading an unwritten index returns stale contents.

Optional Feature:
- Macro: UPLINK_FRAME_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter increments on every accepted frame and wraps at 2^32; cleared by reset only.
  - Its value is stored alongside each captured frame.
  - Read word 8 returns the stored timestamp.
- Undefined:
  - No counter and no extra storage.
  - Word 8 returns 0.

Decomposition:
- Package uplink_frame_capture_pkg:
  - FRAME_W_DEF=234, WORDS_PER_FRAME=8, TS_WORD_IDX=8.
  - State enum {IDLE, ARMED, CAPTURE, DONE}.
  - FEC_CNT_W=16.
- Sub-module uplink_cap_ram: simple dual-port RAM, DEPTH × (FRAME_W [+32]); one synchronous write port, one registered read port.
- Word selection is done in the parent.

Test Plan:
1. Reset, then arm, trig_mode=0, 20 accepted frames with data[31:0]=k → done_o=1, cap_count_o=16; frame 0 word 0 = 0, frame 15 word 0 = 15; rd_valid_o 1 cycle after rd_req_i.
2. trig_mode=1, mask=0xFFFF_FFFF, value=0x0000_0007, frames k=0..30 → frame 0 word 0 = 7, frame 15 word 0 = 22.
3. uplink_rdy_i dropped after 5 captured frames → done_o=1, cap_count_o=5, rdy_lost_o=1; re-arm → rdy_lost_o=0.
4. 70000 accepted frames with frame_fec_i=1 → fec_cnt_o=0xFFFF (saturated); arm → 0.
5. abort_i and arm_i in the same cycle while CAPTURE → state IDLE, busy_o=0, done_o=0.
6. Frame with bits[233:224]=0x3FF, read word 7 → 0x0000_03FF; word 9 → 0. With the macro defined: word 8 = accepted-frame count at capture time.
